// File: rtl/reg_bank.sv
// reg_bank: N independent K-bit registers with a valid/ready write port,
// eight update modes, a 1-cycle-latency read port and a coherent snapshot
// path (shadow copy held stable for HOLD_CYC cycles, flagged by a toggle).
module reg_bank #(
   parameter int unsigned K        = 8,
   parameter int unsigned N        = 4,
   parameter int unsigned ADDR_W   = 2,
   parameter int unsigned HOLD_CYC = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [2:0]        wr_mode,
   input  logic [K-1:0]      wr_data,
   input  logic              rd_valid,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_data_valid,
   output logic [K-1:0]      rd_data,
   input  logic              snap_req,
   output logic              snap_busy,
   output logic              snap_toggle,
   output logic [N*K-1:0]    snap_data
);

   localparam int unsigned CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      M_LOAD = 3'd0,
      M_HOLD = 3'd1,
      M_SHL  = 3'd2,
      M_SHR  = 3'd3,
      M_INC  = 3'd4,
      M_DEC  = 3'd5,
      M_CLR  = 3'd6,
      M_OR   = 3'd7
   } mode_t;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] hold_cnt;
   logic             cap_en;
   logic             wr_fire;
   logic [K-1:0]     regs [N];
   logic [K-1:0]     rd_mux;

   // New value of a register for the requested update mode
   function automatic logic [K-1:0] upd(input logic [K-1:0] r,
                                        input logic [2:0]   mode,
                                        input logic [K-1:0] d);
      logic [K-1:0] v;
      v = r;
      case (mode_t'(mode))
         M_LOAD:  v = d;
         M_HOLD:  v = r;
         M_SHL:   v = {r[K-2:0], d[0]};
         M_SHR:   v = {d[0], r[K-1:1]};
         M_INC:   v = r + K'(1);
         M_DEC:   v = r - K'(1);
         M_CLR:   v = '0;
         M_OR:    v = r | d;
         default: v = r;
      endcase
      return v;
   endfunction

   assign wr_fire = wr_valid & wr_ready;

   // Snapshot FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Snapshot FSM next-state logic; snap_req only matters in IDLE
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (snap_req) state_nx = S_CAPTURE;
         S_CAPTURE: state_nx = S_HOLD;
         S_HOLD:    if (hold_cnt == '0) state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   // Snapshot FSM outputs: writes stall only during the capture cycle
   always_comb begin
      wr_ready  = 1'b1;
      snap_busy = 1'b0;
      cap_en    = 1'b0;
      case (state)
         S_CAPTURE: begin
            wr_ready = 1'b0;
            cap_en   = 1'b1;
         end
         S_HOLD:    snap_busy = 1'b1;
         default:   ;
      endcase
   end

   // Hold-window counter: loads at capture exit, counts down to zero in HOLD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         hold_cnt <= '0;
      else if (cap_en)
         hold_cnt <= CNT_W'(HOLD_CYC - 1);
      else if (state == S_HOLD && hold_cnt != '0)
         hold_cnt <= hold_cnt - CNT_W'(1);
   end

   // Register file update; out-of-range addresses complete the handshake only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N; i++) regs[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < N; i++)
            if (wr_fire && wr_addr == ADDR_W'(i))
               regs[i] <= upd(regs[i], wr_mode, wr_data);
      end
   end

   // Read mux; unmatched (out-of-range) addresses return zero
   always_comb begin
      rd_mux = '0;
      for (int unsigned i = 0; i < N; i++)
         if (rd_addr == ADDR_W'(i)) rd_mux = regs[i];
   end

   // Read response: pre-write value, data holds when no request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_valid <= 1'b0;
         rd_data       <= '0;
      end else begin
         rd_data_valid <= rd_valid;
         if (rd_valid) rd_data <= rd_mux;
      end
   end

   // Shadow copy and toggle change only at the capture-exit edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_data   <= '0;
         snap_toggle <= 1'b0;
      end else if (cap_en) begin
         for (int unsigned i = 0; i < N; i++) snap_data[i*K +: K] <= regs[i];
         snap_toggle <= ~snap_toggle;
      end
   end

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank (N=4 main instance, plus an
// N=3 instance sharing the inputs for out-of-range address behaviour).
module tb_reg_bank;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid;
   logic [1:0]  wr_addr;
   logic [2:0]  wr_mode;
   logic [7:0]  wr_data;
   logic        rd_valid;
   logic [1:0]  rd_addr;
   logic        snap_req;

   logic        wr_ready, rd_data_valid, snap_busy, snap_toggle;
   logic [7:0]  rd_data;
   logic [31:0] snap_data;

   logic        wr_ready3, rd_data_valid3, snap_busy3, snap_toggle3;
   logic [7:0]  rd_data3;
   logic [23:0] snap_data3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_bank #(.K(8), .N(4), .ADDR_W(2), .HOLD_CYC(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_mode(wr_mode), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_addr(rd_addr),
      .rd_data_valid(rd_data_valid), .rd_data(rd_data),
      .snap_req(snap_req), .snap_busy(snap_busy),
      .snap_toggle(snap_toggle), .snap_data(snap_data)
   );

   reg_bank #(.K(8), .N(3), .ADDR_W(2), .HOLD_CYC(4)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready3), .wr_addr(wr_addr),
      .wr_mode(wr_mode), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_addr(rd_addr),
      .rd_data_valid(rd_data_valid3), .rd_data(rd_data3),
      .snap_req(snap_req), .snap_busy(snap_busy3),
      .snap_toggle(snap_toggle3), .snap_data(snap_data3)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [2:0] m, input logic [7:0] d);
      wr_valid = 1'b1; wr_addr = a; wr_mode = m; wr_data = d;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic do_read(input logic [1:0] a, output logic [7:0] d, output logic v);
      rd_valid = 1'b1; rd_addr = a;
      tick();
      d = rd_data; v = rd_data_valid;
      rd_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_mode = '0; wr_data = '0;
      rd_valid = 1'b0; rd_addr = '0; snap_req = 1'b0;
      #3;
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
      checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_data_valid); end
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
      checks++; if (snap_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", snap_busy); end
      checks++; if (snap_toggle !== 1'b0) begin errors++; $display("FAIL reset_toggle: got %b expected 0", snap_toggle); end
      checks++; if (snap_data !== 32'h0) begin errors++; $display("FAIL reset_snap_data: got %h expected 0", snap_data); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_load;
      logic [7:0] d; logic v;
      logic [7:0] exp_r [4];
      exp_r = '{8'h00, 8'hA5, 8'h00, 8'h00};
      do_write(2'd1, 3'd0, 8'hA5);
      do_read(2'd1, d, v);
      checks++; if (d !== 8'hA5) begin errors++; $display("FAIL load_rd_data: got %h expected a5", d); end
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL load_rd_valid: got %b expected 1", v); end
      tick();
      checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL load_valid_one_cycle: got %b expected 0", rd_data_valid); end
      checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL load_rd_hold: got %h expected a5", rd_data); end
      for (int i = 0; i < 4; i++) begin
         do_read(2'(i), d, v);
         checks++; if (d !== exp_r[i]) begin errors++; $display("FAIL load_reg%0d: got %h expected %h", i, d, exp_r[i]); end
      end
   endtask

   task automatic test_modes;
      logic [7:0] d; logic v;
      logic [18:0] vec [10];
      vec = '{{3'd0, 8'h81, 8'h81},   // LOAD
              {3'd2, 8'hFE, 8'h02},   // SHL din0=0
              {3'd3, 8'h01, 8'h81},   // SHR din0=1
              {3'd1, 8'hFF, 8'h81},   // HOLD
              {3'd7, 8'h70, 8'hF1},   // OR
              {3'd6, 8'h5A, 8'h00},   // CLR
              {3'd5, 8'h00, 8'hFF},   // DEC wraps
              {3'd4, 8'h00, 8'h00},   // INC wraps
              {3'd2, 8'h01, 8'h01},   // SHL din0=1
              {3'd4, 8'h00, 8'h02}};  // INC
      for (int i = 0; i < 10; i++) begin
         do_write(2'd0, vec[i][18:16], vec[i][15:8]);
         do_read(2'd0, d, v);
         checks++; if (d !== vec[i][7:0]) begin errors++; $display("FAIL mode_step%0d(mode %0d): got %h expected %h", i, vec[i][18:16], d, vec[i][7:0]); end
      end
   endtask

   task automatic test_same_edge;
      logic [7:0] d; logic v;
      do_write(2'd2, 3'd0, 8'h22);
      wr_valid = 1'b1; wr_addr = 2'd2; wr_mode = 3'd0; wr_data = 8'h11;
      rd_valid = 1'b1; rd_addr = 2'd2;
      tick();
      wr_valid = 1'b0; rd_valid = 1'b0;
      checks++; if (rd_data !== 8'h22) begin errors++; $display("FAIL same_edge_old: got %h expected 22", rd_data); end
      do_read(2'd2, d, v);
      checks++; if (d !== 8'h11) begin errors++; $display("FAIL same_edge_new: got %h expected 11", d); end
   endtask

   task automatic test_out_of_range;
      logic [7:0] d; logic v;
      logic [7:0] exp3 [3];
      exp3 = '{8'h02, 8'hA5, 8'h11};
      wr_valid = 1'b1; wr_addr = 2'd3; wr_mode = 3'd0; wr_data = 8'h5A;
      #1;
      checks++; if (wr_ready3 !== 1'b1) begin errors++; $display("FAIL oor_wr_ready: got %b expected 1", wr_ready3); end
      tick();
      wr_valid = 1'b0;
      do_read(2'd3, d, v);
      checks++; if (rd_data3 !== 8'h00) begin errors++; $display("FAIL oor_read_n3: got %h expected 00", rd_data3); end
      checks++; if (rd_data_valid3 !== 1'b1) begin errors++; $display("FAIL oor_read_valid_n3: got %b expected 1", rd_data_valid3); end
      checks++; if (d !== 8'h5A) begin errors++; $display("FAIL oor_read_n4: got %h expected 5a", d); end
      for (int i = 0; i < 3; i++) begin
         do_read(2'(i), d, v);
         checks++; if (rd_data3 !== exp3[i]) begin errors++; $display("FAIL oor_reg%0d_n3: got %h expected %h", i, rd_data3, exp3[i]); end
      end
      checks++; if ({snap_busy3, snap_toggle3, snap_data3} !== 26'h0) begin errors++; $display("FAIL oor_snap_idle_n3: got %b/%b/%h expected 0/0/0", snap_busy3, snap_toggle3, snap_data3); end
   endtask

   task automatic test_snapshot;
      logic [7:0] d; logic v;
      int busy_cnt;
      for (int i = 0; i < 4; i++) do_write(2'(i), 3'd0, 8'(i + 1));
      snap_req = 1'b1;
      wr_valid = 1'b1; wr_addr = 2'd0; wr_mode = 3'd0; wr_data = 8'h55;
      tick();
      snap_req = 1'b0; wr_valid = 1'b0;
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL snap_capture_ready: got %b expected 0", wr_ready); end
      checks++; if (snap_toggle !== 1'b0) begin errors++; $display("FAIL snap_toggle_before: got %b expected 0", snap_toggle); end
      checks++; if (snap_data !== 32'h0) begin errors++; $display("FAIL snap_data_before: got %h expected 0", snap_data); end
      tick();
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL snap_hold_ready: got %b expected 1", wr_ready); end
      checks++; if (snap_data !== 32'h04030255) begin errors++; $display("FAIL snap_data: got %h expected 04030255", snap_data); end
      checks++; if (snap_toggle !== 1'b1) begin errors++; $display("FAIL snap_toggle_after: got %b expected 1", snap_toggle); end
      busy_cnt = snap_busy ? 1 : 0;
      wr_valid = 1'b1; wr_addr = 2'd1; wr_mode = 3'd0; wr_data = 8'hEE;
      for (int k = 0; k < 10; k++) begin
         tick();
         wr_valid = 1'b0;
         if (!snap_busy) break;
         busy_cnt++;
      end
      checks++; if (busy_cnt !== 4) begin errors++; $display("FAIL snap_busy_len: got %0d expected 4", busy_cnt); end
      checks++; if (snap_data !== 32'h04030255) begin errors++; $display("FAIL snap_data_stable: got %h expected 04030255", snap_data); end
      do_read(2'd1, d, v);
      checks++; if (d !== 8'hEE) begin errors++; $display("FAIL snap_hold_write: got %h expected ee", d); end
   endtask

   task automatic test_held_req;
      logic [11:0] busy_v, tog_v, rdy_v;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      do_write(2'd0, 3'd0, 8'h3C);
      snap_req = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         busy_v[k] = snap_busy; tog_v[k] = snap_toggle; rdy_v[k] = wr_ready;
      end
      snap_req = 1'b0;
      checks++; if (busy_v !== 12'b011110011110) begin errors++; $display("FAIL held_busy_pattern: got %b expected 011110011110", busy_v); end
      checks++; if (tog_v !== 12'b000001111110) begin errors++; $display("FAIL held_toggle_pattern: got %b expected 000001111110", tog_v); end
      checks++; if (rdy_v !== 12'b111110111110) begin errors++; $display("FAIL held_ready_pattern: got %b expected 111110111110", rdy_v); end
      checks++; if (snap_data !== 32'h0000003C) begin errors++; $display("FAIL held_snap_data: got %h expected 0000003c", snap_data); end
      tick(); tick();
      checks++; if ({snap_busy, snap_toggle} !== 2'b00) begin errors++; $display("FAIL held_idle_after: got %b expected 00", {snap_busy, snap_toggle}); end
   endtask

   task automatic test_no_queue;
      int busy_cnt, tog_chg;
      logic last_tog;
      busy_cnt = 0; tog_chg = 0; last_tog = snap_toggle;
      for (int k = 0; k < 10; k++) begin
         snap_req = (k == 0 || k == 2);
         tick();
         if (snap_busy) busy_cnt++;
         if (snap_toggle !== last_tog) tog_chg++;
         last_tog = snap_toggle;
      end
      snap_req = 1'b0;
      checks++; if (busy_cnt !== 4) begin errors++; $display("FAIL noqueue_busy_cycles: got %0d expected 4", busy_cnt); end
      checks++; if (tog_chg !== 1) begin errors++; $display("FAIL noqueue_toggle_flips: got %0d expected 1", tog_chg); end
      checks++; if (snap_toggle !== 1'b1) begin errors++; $display("FAIL noqueue_toggle_final: got %b expected 1", snap_toggle); end
   endtask

   task automatic test_reset_mid;
      logic [7:0] d; logic v;
      for (int i = 0; i < 4; i++) do_write(2'(i), 3'd0, 8'hC0 + 8'(i));
      do_read(2'd3, d, v);
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      tick();
      checks++; if (snap_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", snap_busy); end
      checks++; if (snap_data !== 32'hC3C2C1C0) begin errors++; $display("FAIL mid_snap_before: got %h expected c3c2c1c0", snap_data); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (snap_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", snap_busy); end
      checks++; if (snap_toggle !== 1'b0) begin errors++; $display("FAIL mid_toggle: got %b expected 0", snap_toggle); end
      checks++; if (snap_data !== 32'h0) begin errors++; $display("FAIL mid_snap_data: got %h expected 0", snap_data); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL mid_wr_ready: got %b expected 1", wr_ready); end
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL mid_rd_data: got %h expected 00", rd_data); end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         do_read(2'(i), d, v);
         checks++; if (d !== 8'h00) begin errors++; $display("FAIL mid_reg%0d: got %h expected 00", i, d); end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_modes();
      test_same_edge();
      test_out_of_range();
      test_snapshot();
      test_held_req();
      test_no_queue();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
